mod_mul_il: RTL and testbench

- Bit-serial interleaved modular multiplier: res = a*b mod p, 256-bit operands.
- Sits directly downstream of mod_inv in the point-arithmetic datapath and consumes its inv_res, e.g. for the affine conversion x = X*Z^-1 mod p.
- Uses the same start_signal/finish handshake as mod_inv, so a sequencer can chain the two blocks without glue logic.
- Processes one multiplier bit per clock, MSB first, with fixed latency.

---
 rtl/mod_mul_il.sv | 122 ++++++++++++
 tb/tb_mod_mul_il.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_mul_il.sv
// Bit-serial interleaved modular multiplier: res = a*b mod p.
// One multiplier bit per clock, MSB first; fixed latency of WIDTH clocks
// from the start-sampling edge to finish. Shares the start_signal/finish
// handshake of mod_inv so the two blocks can be chained directly.
module mod_mul_il #(
   parameter int WIDTH = 256,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_signal,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] p,
   output logic [WIDTH-1:0] res,
   output logic             finish,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nx;

   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH-1:0]   p_reg;
   logic [WIDTH-1:0]   acc;
   logic [CNT_W-1:0]   cnt;

   logic [WIDTH:0]     dbl;
   logic [WIDTH:0]     dbl_red;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     sum_red;
   logic [WIDTH-1:0]   acc_nx;

   // One conditional subtraction of the modulus; keeps a value below 2p
   // reduced into [0, p) in a single cycle.
   function automatic logic [WIDTH:0] cond_sub(input logic [WIDTH:0]   x,
                                               input logic [WIDTH-1:0] m);
      logic [WIDTH:0] m_ext;
      m_ext = {1'b0, m};
      if (x >= m_ext)
         cond_sub = x - m_ext;
      else
         cond_sub = x;
   endfunction

   // Control state register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic: start accepted only outside CALC; CALC ends on the last bit.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (start_signal) state_nx = CALC;
         CALC:       if (cnt == '0)    state_nx = DONE;
         default:    state_nx = IDLE;
      endcase
   end

   // One interleaved step: acc <- (2*acc + b[i]*a) mod p, both reductions this cycle.
   always_comb begin
      dbl     = {acc, 1'b0};
      dbl_red = cond_sub(dbl, p_reg);
      sum     = dbl_red + {1'b0, a_reg};
      sum_red = b_reg[cnt] ? cond_sub(sum, p_reg) : dbl_red;
      acc_nx  = sum_red[WIDTH-1:0];
   end

   // Operand latch, accumulator/counter update and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg  <= '0;
         b_reg  <= '0;
         p_reg  <= '0;
         acc    <= '0;
         cnt    <= '0;
         res    <= '0;
         finish <= 1'b0;
         busy   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_signal) begin
                  a_reg  <= a;
                  b_reg  <= b;
                  p_reg  <= p;
                  acc    <= '0;
                  cnt    <= CNT_W'(WIDTH - 1);
                  finish <= 1'b0;
                  busy   <= 1'b1;
               end
            end
            CALC: begin
               acc <= acc_nx;
               if (cnt == '0) begin
                  res    <= acc_nx;
                  finish <= 1'b1;
                  busy   <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               finish <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mod_mul_il.sv
// Directed bench for mod_mul_il: reset, small operands, NIST/SM2 vectors,
// random operands against a 512-bit reference, start-during-CALC,
// mid-operation reset and back-to-back operation.
module tb_mod_mul_il;

   localparam int W = 256;
   localparam logic [W-1:0] P7   = 256'd7;
   localparam logic [W-1:0] P256 = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;
   localparam logic [W-1:0] NA   = 256'h69fe7d23f8dd5a7c958acb41a62f15692668b35d2d4ed54c0a8464e387439478;
   localparam logic [W-1:0] NB   = 256'he05215cbc412474d522e1ef9d676888593b586030bce722aa456da5e204fd057;
   localparam logic [W-1:0] PSM2 = 256'hfffffffeffffffffffffffffffffffffffffffff00000000ffffffffffffffff;

   logic         clk;
   logic         rst;
   logic         start_signal;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] p;
   logic [W-1:0] res;
   logic         finish;
   logic         busy;

   int pass_cnt;
   int total_cnt;

   mod_mul_il #(.WIDTH(W), .CNT_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_signal (start_signal),
      .a            (a),
      .b            (b),
      .p            (p),
      .res          (res),
      .finish       (finish),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic [W-1:0] m);
      logic [2*W-1:0] prod;
      prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      prod = prod % {{W{1'b0}}, m};
      return prod[W-1:0];
   endfunction

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < W / 32; k++)
         r = {r[W-33:0], 32'($urandom())};
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start with the given operands, scramble inputs after the
   // sampling edge, then wait for the result; lat_ok reports whether
   // finish stayed low for 255 edges and rose on edge 256 with busy low.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [W-1:0] tp,
                         output logic [W-1:0] r, output bit lat_ok);
      a = ta; b = tb; p = tp; start_signal = 1'b1;
      tick();
      start_signal = 1'b0;
      a = ~ta; b = ~tb; p = ~tp;
      lat_ok = (finish === 1'b0) && (busy === 1'b1);
      for (int i = 1; i < W; i++) begin
         tick();
         if (finish !== 1'b0) lat_ok = 1'b0;
      end
      tick();
      if (finish !== 1'b1 || busy !== 1'b0) lat_ok = 1'b0;
      r = res;
   endtask

   task automatic test_reset();
      rst = 1'b1; start_signal = 1'b0; a = '0; b = '0; p = '0;
      tick(); tick();
      rst = 1'b0;
      total_cnt++;
      if ({res, finish, busy} !== {{W{1'b0}}, 1'b0, 1'b0})
         $display("FAIL reset: res=%h finish=%b busy=%b, expected 0/0/0", res, finish, busy);
      else pass_cnt++;
      tick(); tick();
      total_cnt++;
      if (finish !== 1'b0 || busy !== 1'b0)
         $display("FAIL reset_idle: finish=%b busy=%b, expected 0/0", finish, busy);
      else pass_cnt++;
   endtask

   task automatic test_small();
      logic [W-1:0] r;
      bit           lat;
      bit           hold_ok;
      run_op(256'd3, 256'd5, P7, r, lat);
      total_cnt++;
      if (lat !== 1'b1) $display("FAIL small_latency: lat_ok=%b, expected 1", lat);
      else pass_cnt++;
      total_cnt++;
      if (r !== 256'd1) $display("FAIL small_res: got %0d, expected 1", r);
      else pass_cnt++;
      hold_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (finish !== 1'b1 || res !== 256'd1 || busy !== 1'b0) hold_ok = 1'b0;
      end
      total_cnt++;
      if (!hold_ok) $display("FAIL small_hold: finish=%b res=%0d busy=%b, expected 1/1/0", finish, res, busy);
      else pass_cnt++;
   endtask

   task automatic test_nist();
      logic [W-1:0] r;
      logic [W-1:0] e;
      bit           lat;
      e = ref_mul(NA, NB, P256);
      run_op(NA, NB, P256, r, lat);
      total_cnt++;
      if (r !== e || lat !== 1'b1)
         $display("FAIL nist_pair: got %h lat=%b, expected %h lat=1", r, lat, e);
      else pass_cnt++;
   endtask

   task automatic test_sm2_edges();
      logic [W-1:0] r;
      bit           lat;
      run_op(PSM2 - 1, PSM2 - 1, PSM2, r, lat);
      total_cnt++;
      if (r !== 256'd1 || lat !== 1'b1)
         $display("FAIL sm2_pm1_sq: got %h lat=%b, expected 1 lat=1", r, lat);
      else pass_cnt++;
      run_op('0, PSM2 - 1, PSM2, r, lat);
      total_cnt++;
      if (r !== '0 || lat !== 1'b1)
         $display("FAIL sm2_zero: got %h lat=%b, expected 0 lat=1", r, lat);
      else pass_cnt++;
      run_op(256'h1234_5678_9abc_def0, 256'd1, PSM2, r, lat);
      total_cnt++;
      if (r !== 256'h1234_5678_9abc_def0 || lat !== 1'b1)
         $display("FAIL sm2_b_one: got %h lat=%b, expected 123456789abcdef0", r, lat);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W-1:0] r;
      logic [W-1:0] e;
      bit           lat;
      for (int n = 0; n < 100; n++) begin
         ra = rand_w() % PSM2;
         rb = rand_w() % PSM2;
         e  = ref_mul(ra, rb, PSM2);
         run_op(ra, rb, PSM2, r, lat);
         total_cnt++;
         if (r !== e || lat !== 1'b1)
            $display("FAIL random_%0d: got %h lat=%b, expected %h", n, r, lat, e);
         else pass_cnt++;
      end
   endtask

   task automatic test_start_ignored();
      bit early;
      a = 256'd3; b = 256'd5; p = P7; start_signal = 1'b1;
      tick();
      start_signal = 1'b0;
      early = (finish !== 1'b0);
      for (int i = 1; i < W; i++) begin
         if (i == 99) begin
            a = 256'd2; b = 256'd3; p = 256'd5; start_signal = 1'b1;
         end
         tick();
         if (i == 100) start_signal = 1'b0;
         if (finish !== 1'b0) early = 1'b1;
      end
      total_cnt++;
      if (early) $display("FAIL ignore_early_finish: finish rose before edge 256");
      else pass_cnt++;
      tick();
      total_cnt++;
      if (finish !== 1'b1 || res !== 256'd1)
         $display("FAIL ignore_result: finish=%b res=%0d, expected 1/1", finish, res);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] r;
      bit           lat;
      bit           quiet;
      a = 256'd3; b = 256'd5; p = P7; start_signal = 1'b1;
      tick();
      start_signal = 1'b0;
      for (int i = 1; i < 50; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total_cnt++;
      if (finish !== 1'b0 || res !== '0 || busy !== 1'b0)
         $display("FAIL reset_mid: finish=%b res=%0d busy=%b, expected 0/0/0", finish, res, busy);
      else pass_cnt++;
      quiet = 1'b1;
      for (int i = 0; i < 250; i++) begin
         tick();
         if (finish !== 1'b0 || busy !== 1'b0) quiet = 1'b1 & 1'b0;
      end
      total_cnt++;
      if (!quiet) $display("FAIL reset_mid_quiet: finish=%b busy=%b after abandon, expected 0/0", finish, busy);
      else pass_cnt++;
      run_op(256'd2, 256'd3, P7, r, lat);
      total_cnt++;
      if (r !== 256'd6 || lat !== 1'b1)
         $display("FAIL reset_mid_restart: got %0d lat=%b, expected 6 lat=1", r, lat);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      bit early;
      a = 256'd3; b = 256'd5; p = P7; start_signal = 1'b1;
      tick();
      a = 256'd2; b = 256'd4;
      early = 1'b0;
      for (int i = 1; i < W; i++) begin
         tick();
         if (finish !== 1'b0) early = 1'b1;
      end
      tick();
      total_cnt++;
      if (early || finish !== 1'b1 || res !== 256'd1)
         $display("FAIL b2b_first: early=%b finish=%b res=%0d, expected 0/1/1", early, finish, res);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (finish !== 1'b0 || busy !== 1'b1 || res !== 256'd1)
         $display("FAIL b2b_restart: finish=%b busy=%b res=%0d, expected 0/1/1", finish, busy, res);
      else pass_cnt++;
      start_signal = 1'b0;
      a = 256'd6; b = 256'd6;
      early = 1'b0;
      for (int i = 1; i < W; i++) begin
         tick();
         if (finish !== 1'b0) early = 1'b1;
      end
      tick();
      total_cnt++;
      if (early || finish !== 1'b1 || res !== 256'd1)
         $display("FAIL b2b_second: early=%b finish=%b res=%0d, expected 0/1/1", early, finish, res);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      rst = 1'b1; start_signal = 1'b0; a = '0; b = '0; p = '0;
      test_reset();
      test_small();
      test_nist();
      test_sm2_edges();
      test_random();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
